iddr_delay_calib: RTL and testbench

//  Input-delay training controller for the iddr capture block. On start it sweeps the shared
//  9-bit delay tap from 0 to MAX_TAP while a known training pattern arrives on d, and checks
//  q1/q2 at every tap. It finds the longest contiguous passing window, loads the window centre

---
 rtl/iddr_calib_pkg.sv | 28 ++
 rtl/iddr_calib_window.sv | 56 +++++
 rtl/iddr_delay_calib.sv | 182 ++++++++++++++++++
 tb/tb_iddr_delay_calib.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iddr_calib_pkg.sv
// Shared definitions for the iddr input-delay training controller.
// Holds the tap width of the delay primitive, the controller state encoding
// and the helper that locates one lane's tap count inside dly_cnt_out.
package iddr_calib_pkg;

   // Tap counter width of the delay primitive.
   localparam int TAP_W = 9;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ZERO,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_STEP,
      ST_CALC,
      ST_LOAD,
      ST_CHECK,
      ST_LOCK,
      ST_FAIL
   } calib_state_t;

   // LSB position of a lane's tap count in the concatenated cnt_value_out bus.
   function automatic int lane_lsb(input int lane);
      return lane * TAP_W;
   endfunction

endpackage

// File: rtl/iddr_calib_window.sv
// Passing-window tracker: follows the current run of passing taps and keeps
// the longest run seen so far (ties keep the earlier, lower-tap run).
// Ports: clk/rst, clr (new training), eval (one tap result), pass, last (tap is
//   the final tap, closes any open run), tap; best_start/best_len results.
// Latency: best_* are valid the cycle after the eval strobe. No backpressure.
module iddr_calib_window
   import iddr_calib_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             eval,
   input  logic             pass,
   input  logic             last,
   input  logic [TAP_W-1:0] tap,
   output logic [TAP_W-1:0] best_start,
   output logic [TAP_W:0]   best_len
);

   logic [TAP_W-1:0] run_start;
   logic [TAP_W:0]   run_len;
   logic [TAP_W-1:0] cand_start;
   logic [TAP_W:0]   cand_len;
   logic             close_run;

   // Candidate run including this tap; it is the run that gets judged when it closes.
   always_comb begin
      cand_start = run_start;
      cand_len   = run_len;
      if (pass) begin
         cand_len = run_len + 1'b1;
         if (run_len == '0) begin
            cand_start = tap;
         end
      end
      close_run = !pass || last;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         run_start  <= '0;
         run_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else if (eval) begin
         run_start <= cand_start;
         run_len   <= (pass && !last) ? cand_len : '0;
         // Strictly longer only: an equal later run never displaces the earlier one.
         if (close_run && (cand_len > best_len)) begin
            best_start <= cand_start;
            best_len   <= cand_len;
         end
      end
   end

endmodule

// File: rtl/iddr_delay_calib.sv
// Input-delay training for the iddr capture block: sweeps the shared tap from
// 0 to MAX_TAP against a known pattern, loads the centre of the longest
// passing window, verifies it by read-back, then hands back to VT tracking.
// Ports: start/busy/done/error handshake to bring-up logic; q1/q2/dly_cnt_out
//   from the iddr; dly_en/dly_inc/dly_load/dly_cnt_in/dly_en_vtc to the iddr;
//   eye_start/eye_len/centre report the chosen window.
// Latency: roughly (MAX_TAP+1)*(SETTLE_CYCLES+SAMPLE_CYCLES+3) cycles. start is
//   ignored while busy; no other flow control.
module iddr_delay_calib
   import iddr_calib_pkg::*;
#(
   parameter int               WIDTH         = 1,
   parameter int               MAX_TAP       = 511,
   parameter int               SETTLE_CYCLES = 16,
   parameter int               SAMPLE_CYCLES = 64,
   parameter logic [WIDTH-1:0] EXPECT_Q1     = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] EXPECT_Q2     = {WIDTH{1'b0}}
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WIDTH-1:0]       q1,
   input  logic [WIDTH-1:0]       q2,
   input  logic [WIDTH*TAP_W-1:0] dly_cnt_out,
   output logic                   dly_en,
   output logic                   dly_inc,
   output logic                   dly_load,
   output logic [TAP_W-1:0]       dly_cnt_in,
   output logic                   dly_en_vtc,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [TAP_W-1:0]       eye_start,
   output logic [TAP_W:0]         eye_len,
   output logic [TAP_W-1:0]       centre
);

   localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0]      SAMPLE_LAST = 16'(SAMPLE_CYCLES - 1);
   localparam logic [15:0]      LOAD_LAST   = 16'(SETTLE_CYCLES);
   localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAP);

   calib_state_t     state;
   calib_state_t     state_nxt;
   logic [15:0]      cnt;
   logic [TAP_W-1:0] tap;
   logic             pass_acc;
   logic             sample_ok;
   logic             win_eval;
   logic             win_clr;
   logic             tap_is_last;
   logic [TAP_W-1:0] best_start;
   logic [TAP_W:0]   best_len;
   logic [TAP_W-1:0] centre_calc;
   logic             cnt_ok;

   assign sample_ok   = (q1 == EXPECT_Q1) && (q2 == EXPECT_Q2);
   assign tap_is_last = (tap == LAST_TAP);
   assign win_clr     = (state == ST_IDLE) && start;
   assign centre_calc = best_start + TAP_W'(best_len >> 1);

   // Read-back passes only if every lane reports the loaded centre.
   always_comb begin
      cnt_ok = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (dly_cnt_out[lane_lsb(i) +: TAP_W] != centre) begin
            cnt_ok = 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      dly_en     = 1'b0;
      dly_inc    = 1'b0;
      dly_load   = 1'b0;
      dly_en_vtc = 1'b0;
      busy       = 1'b1;
      win_eval   = 1'b0;
      case (state)
         ST_IDLE: begin
            busy       = 1'b0;
            dly_en_vtc = 1'b1;
            if (start) state_nxt = ST_ZERO;
         end
         ST_ZERO: begin
            dly_load  = 1'b1;
            state_nxt = ST_SETTLE;
         end
         ST_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
         ST_SAMPLE: if (cnt == SAMPLE_LAST) state_nxt = ST_EVAL;
         ST_EVAL: begin
            win_eval  = 1'b1;
            state_nxt = tap_is_last ? ST_CALC : ST_STEP;
         end
         ST_STEP: begin
            // inc held for two cycles around a single en pulse: one rising edge per step.
            dly_inc = 1'b1;
            dly_en  = (cnt == '0);
            if (cnt != '0) state_nxt = ST_SETTLE;
         end
         ST_CALC:  state_nxt = (best_len == '0) ? ST_FAIL : ST_LOAD;
         ST_LOAD: begin
            dly_load = (cnt == '0);
            if (cnt == LOAD_LAST) state_nxt = ST_CHECK;
         end
         ST_CHECK: state_nxt = cnt_ok ? ST_LOCK : ST_FAIL;
         ST_LOCK, ST_FAIL: begin
            busy       = 1'b0;
            dly_en_vtc = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            dly_en_vtc = 1'b1;
            state_nxt  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
      end else begin
         state      <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         tap        <= '0;
         pass_acc   <= 1'b0;
         dly_cnt_in <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         eye_start  <= '0;
         eye_len    <= '0;
         centre     <= '0;
      end else begin
         // Per-state cycle counter restarts on every state change.
         cnt <= ((state_nxt != state) || (state == ST_IDLE)) ? '0 : cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  done       <= 1'b0;
                  error      <= 1'b0;
                  dly_cnt_in <= '0;
                  tap        <= '0;
               end
            end
            ST_SETTLE: pass_acc <= 1'b1;
            ST_SAMPLE: pass_acc <= pass_acc & sample_ok;
            ST_STEP:   if (cnt != '0) tap <= tap + 1'b1;
            ST_CALC: begin
               if (best_len != '0) begin
                  eye_start  <= best_start;
                  eye_len    <= best_len;
                  centre     <= centre_calc;
                  dly_cnt_in <= centre_calc;
               end
            end
            default: ;
         endcase
         if ((state_nxt == ST_LOCK) || (state_nxt == ST_FAIL)) done  <= 1'b1;
         if (state_nxt == ST_FAIL)                             error <= 1'b1;
      end
   end

   iddr_calib_window u_window (
      .clk        (clk),
      .rst        (rst),
      .clr        (win_clr),
      .eval       (win_eval),
      .pass       (pass_acc),
      .last       (tap_is_last),
      .tap        (tap),
      .best_start (best_start),
      .best_len   (best_len)
   );

endmodule

// File: tb/tb_iddr_delay_calib.sv
// Bench for iddr_delay_calib: behavioural iddr delay model with per-tap pass
// map, reference window search over that map, and a done-triggered scoreboard.
// Ports: all DUT ports driven/observed; WIDTH=2 lanes, short settle/sample times.
module tb_iddr_delay_calib;
   localparam int WIDTH   = 2;
   localparam int TW      = 9;
   localparam int MAX_TAP = 511;
   localparam int SETTLE  = 4;
   localparam int SAMPLE  = 2;
   localparam int BUDGET  = 6000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [WIDTH-1:0]    q1, q2;
   logic [WIDTH*TW-1:0] dly_cnt_out;
   logic                dly_en, dly_inc, dly_load, dly_en_vtc;
   logic [TW-1:0]       dly_cnt_in;
   logic                busy, done, error;
   logic [TW-1:0]       eye_start, centre;
   logic [TW:0]         eye_len;

   iddr_delay_calib #(
      .WIDTH(WIDTH), .MAX_TAP(MAX_TAP), .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .q1(q1), .q2(q2), .dly_cnt_out(dly_cnt_out),
      .dly_en(dly_en), .dly_inc(dly_inc), .dly_load(dly_load), .dly_cnt_in(dly_cnt_in),
      .dly_en_vtc(dly_en_vtc), .busy(busy), .done(done), .error(error),
      .eye_start(eye_start), .eye_len(eye_len), .centre(centre)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural iddr ----------------
   // mode per tap: 0 = wrong data, 1 = clean pass, 2 = marginal (wrong every other cycle)
   int          mode [MAX_TAP+1];
   logic [TW-1:0] m_tap = '0;
   logic [TW-1:0] off0 = '0, off1 = '0;
   logic        en_d = 1'b0;
   bit          par = 1'b0;
   int          e_lane = 0, e_kind = 0;
   bit          ok;

   always @(posedge clk) begin
      en_d   <= dly_en;
      par    <= ~par;
      e_lane <= $urandom_range(0, WIDTH-1);
      e_kind <= $urandom_range(0, 2);
      if (dly_load)
         m_tap <= dly_cnt_in;
      else if (dly_en && !en_d)
         m_tap <= dly_inc ? m_tap + 1'b1 : m_tap - 1'b1;
   end

   always_comb begin
      ok = (mode[m_tap] == 1) || ((mode[m_tap] == 2) && par);
      q1 = {WIDTH{1'b1}};
      q2 = {WIDTH{1'b0}};
      if (!ok) begin
         if (e_kind != 1) q1[e_lane] = 1'b0;
         if (e_kind != 0) q2[e_lane] = 1'b1;
      end
   end

   assign dly_cnt_out = {TW'(m_tap + off1), TW'(m_tap + off0)};

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      int err; int has_eye; int eye_start; int eye_len; int centre; int last_load;
   } exp_t;
   exp_t sb[$];

   // Longest strictly-passing run; a later run must be longer to win.
   task automatic ref_model(output exp_t e);
      int cur, bl, bs;
      cur = 0; bl = 0; bs = 0;
      for (int t = 0; t <= MAX_TAP; t++) begin
         if (mode[t] == 1) begin
            cur++;
            if (cur > bl) begin bl = cur; bs = t - cur + 1; end
         end else cur = 0;
      end
      e.has_eye   = (bl != 0);
      e.eye_start = bs;
      e.eye_len   = bl;
      e.centre    = bs + bl / 2;
      if (bl == 0) begin
         e.err = 1; e.last_load = 0;
      end else begin
         e.err = (off0 != 0 || off1 != 0) ? 1 : 0;
         e.last_load = e.centre;
      end
   endtask

   // Monitor: tracks delay-port activity per run and checks results on done.
   initial begin
      int edges, viol, last_load;
      bit busy_q, done_q, en_q;
      exp_t e;
      edges = 0; viol = 0; last_load = -1; busy_q = 0; done_q = 0; en_q = 0;
      forever begin
         @(negedge clk);
         if (busy && !busy_q) begin edges = 0; viol = 0; last_load = -1; end
         if (dly_en && !en_q) edges++;
         if ((dly_load || dly_en || dly_inc) && dly_en_vtc) viol++;
         if (dly_load) last_load = int'(dly_cnt_in);
         if (done && !done_q) begin
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL spurious_done: done rose with no run outstanding");
            end else begin
               e = sb.pop_front();
               check("error", int'(error), e.err);
               check("busy_at_done", int'(busy), 0);
               check("vtc_at_done", int'(dly_en_vtc), 1);
               check("en_edges", edges, MAX_TAP);
               check("vtc_during_step_load", viol, 0);
               check("last_load", last_load, e.last_load);
               if (e.has_eye) begin
                  check("eye_start", int'(eye_start), e.eye_start);
                  check("eye_len", int'(eye_len), e.eye_len);
                  check("centre", int'(centre), e.centre);
               end
            end
         end
         busy_q = busy; done_q = done; en_q = dly_en;
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_map();
      for (int t = 0; t <= MAX_TAP; t++) mode[t] = 0;
   endtask

   task automatic set_win(input int a, input int b);
      for (int t = a; t <= b; t++) mode[t] = 1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_sb();
      int c;
      c = 0;
      while (sb.size() != 0 && c < BUDGET) begin @(posedge clk); c++; end
      if (sb.size() != 0) begin
         vectors++; miscompares++;
         $display("FAIL timeout: run not done after %0d cycles", BUDGET);
         @(posedge clk); #1 rst = 1'b1;
         @(posedge clk); #1 rst = 1'b0;
         sb.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic run(input bit poke);
      exp_t e;
      ref_model(e);
      sb.push_back(e);
      pulse_start();
      if (poke) begin
         repeat (300) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         @(negedge clk);
         check("busy_after_poke", int'(busy), 1);
      end
      wait_sb();
   endtask

   task automatic random_map();
      int a, len, b;
      clear_map();
      for (int t = 0; t <= MAX_TAP; t++) if ($urandom_range(0, 15) == 0) mode[t] = 1;
      a   = $urandom_range(1, 440);
      len = $urandom_range(1, 60);
      b   = a + len - 1;
      set_win(a, b);
      mode[a-1] = 2;
      if (b < MAX_TAP) mode[b+1] = 2;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dly_en"}, int'(dly_en), 0);
      check({tag, "_dly_inc"}, int'(dly_inc), 0);
      check({tag, "_dly_load"}, int'(dly_load), 0);
      check({tag, "_dly_cnt_in"}, int'(dly_cnt_in), 0);
      check({tag, "_dly_en_vtc"}, int'(dly_en_vtc), 1);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_error"}, int'(error), 0);
      check({tag, "_eye_start"}, int'(eye_start), 0);
      check({tag, "_eye_len"}, int'(eye_len), 0);
      check({tag, "_centre"}, int'(centre), 0);
   endtask

   initial begin
      int c;
      clear_map();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      clear_map(); set_win(100, 179);                run(0);
      clear_map(); set_win(10, 29); set_win(300, 319); run(0);
      clear_map(); set_win(0, MAX_TAP);              run(0);
      clear_map();                                   run(0);
      clear_map(); set_win(480, 511);                run(0);
      clear_map(); set_win(7, 7);                    run(0);
      clear_map(); set_win(100, 179); off0 = 9'd1;   run(0);
      off0 = '0; off1 = 9'd1;                        run(0);
      off1 = '0;

      // Reset in the middle of the sweep.
      clear_map(); set_win(50, 60);
      pulse_start();
      c = 0;
      while (!busy && c < 20) begin @(posedge clk); c++; end
      check("busy_before_abort", int'(busy), 1);
      repeat (1000) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("abort");
      repeat (3) @(posedge clk);

      random_map(); run(1);
      random_map(); run(0);
      random_map(); run(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
